local_arbiter: RTL and testbench
================================

LOCAL_ARBITER -- requirements
Module: local_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 3, meaning number of requesting ports.
REQ-002 SHALL have parameter AW, default 23, meaning local address width in 32-bit words.
REQ-003 SHALL have parameter SW, default 7, meaning burst size field width.
REQ-004 SHALL have port local_clk_i, input, 1, the sole clock; all logic on its rising edge.
REQ-005 SHALL have port local_reset_n_i, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port port_req_i, input, PORTS; per-port transfer request, held high until port_done_o.
REQ-007 SHALL have port port_we_i, input, PORTS; 1 means write, 0 means read.
REQ-008 SHALL have port port_adr_i, input, PORTS*AW; start word address, port n at [n*AW+:AW].
REQ-009 SHALL have port port_size_i, input, PORTS*SW; burst beats.
REQ-010 SHALL have port port_wdata_i, input, PORTS*32; current write beat.
REQ-011 SHALL have port port_be_i, input, PORTS*4; byte enables of current beat.
REQ-012 SHALL have port port_wdata_rd_o, output, PORTS; one-cycle pop strobe per accepted write beat.
REQ-013 SHALL have port port_rdata_o, output, 32; shared read data.
REQ-014 SHALL have port port_rdata_valid_o, output, PORTS; read beat valid for port n.
REQ-015 SHALL have port port_done_o, output, PORTS; one-cycle pulse on completion.
REQ-016 SHALL have outputs local_address_o (AW), local_write_req_o, local_read_req_o, local_burstbegin_o (1 each), local_wdata_o (32), local_be_o (4), local_size_o (SW).
REQ-017 SHALL have inputs local_ready_i (1), local_rdata_i (32), local_rdata_valid_i (1).

Function
REQ-018 SHALL implement states IDLE, WRITE, READ_CMD, READ_DATA.
REQ-019 IDLE: any port_req_i high -> grant first requester in order last+1, last+2, ... mod PORTS; latch index, address, size, we; next state WRITE or READ_CMD.
REQ-020 Round-robin pointer last SHALL update to granted index at grant.
REQ-021 Latched size 0 SHALL be treated as 1 beat; local_size_o drives effective size.
REQ-022 WRITE: local_write_req_o=1, local_wdata_o/local_be_o pass granted port's inputs combinationally, local_address_o=latched address.
REQ-023 A write beat SHALL be accepted in each cycle with local_write_req_o & local_ready_i; that cycle port_wdata_rd_o[grant]=1 and beat counter increments.
REQ-024 local_burstbegin_o SHALL be high while first beat (write) or read command is not yet accepted, low otherwise.
REQ-025 After last write beat accepted: port_done_o[grant] pulses next cycle, state IDLE.
REQ-026 READ_CMD: local_read_req_o=1 until local_ready_i high, then READ_DATA.
REQ-027 READ_DATA: each local_rdata_valid_i SHALL produce port_rdata_valid_o[grant]=1 and port_rdata_o=local_rdata_i one cycle later (registered).
REQ-028 After last read beat: port_done_o[grant] pulses in the same cycle as the last port_rdata_valid_o, state IDLE.
REQ-029 local_rdata_valid_i outside READ_DATA SHALL be ignored.
REQ-030 port_req_i dropping mid-transfer SHALL not abort the transfer.
REQ-031 Minimum one IDLE cycle between transfers; grant decision only in IDLE.
REQ-032 Non-granted ports SHALL see port_wdata_rd_o, port_rdata_valid_o, port_done_o low.

Reset
REQ-033 Reset low SHALL force state IDLE, counters 0, last=PORTS-1, all outputs 0, at any time including mid-burst.
REQ-034 After reset release the first grant with all ports requesting SHALL be port 0.

Verification
REQ-035 Port 1 write, adr 0x100, size 4, local_ready_i=1 -> write_req 4 cycles, burstbegin only cycle 1, 4 pops, done[1] pulse.
REQ-036 Port 0 read size 8, ready low 3 cycles -> read_req+burstbegin held 4 cycles; 8 rdata_valid -> 8 port_rdata_valid_o[0] one cycle delayed, done[0] with last.
REQ-037 All three ports requesting continuously -> grants 0,1,2,0,1,2.
REQ-038 Write size 4, ready toggling 1,0,1,0 -> exactly 4 pops only on ready-high cycles, data held otherwise.
REQ-039 Size 0 read -> local_size_o=1, one beat, done.
REQ-040 Reset asserted mid read burst -> all outputs 0 immediately; after release, stray rdata_valid ignored, port 0 granted first.

Source files
------------

// File: rtl/local_arbiter.sv
// local_arbiter: round-robin arbiter that multiplexes several burst masters
// onto a single local (Avalon-style) memory port. One transfer is in
// flight at a time; the grant is decided only in IDLE.
module local_arbiter #(
  parameter int PORTS = 3,
  parameter int AW    = 23,
  parameter int SW    = 7
) (
  input  logic                  local_clk_i,
  input  logic                  local_reset_n_i,
  input  logic [PORTS-1:0]      port_req_i,
  input  logic [PORTS-1:0]      port_we_i,
  input  logic [PORTS*AW-1:0]   port_adr_i,
  input  logic [PORTS*SW-1:0]   port_size_i,
  input  logic [PORTS*32-1:0]   port_wdata_i,
  input  logic [PORTS*4-1:0]    port_be_i,
  output logic [PORTS-1:0]      port_wdata_rd_o,
  output logic [31:0]           port_rdata_o,
  output logic [PORTS-1:0]      port_rdata_valid_o,
  output logic [PORTS-1:0]      port_done_o,
  output logic [AW-1:0]         local_address_o,
  output logic                  local_write_req_o,
  output logic                  local_read_req_o,
  output logic                  local_burstbegin_o,
  output logic [31:0]           local_wdata_o,
  output logic [3:0]            local_be_o,
  output logic [SW-1:0]         local_size_o,
  input  logic                  local_ready_i,
  input  logic [31:0]           local_rdata_i,
  input  logic                  local_rdata_valid_i
);

  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITE     = 2'd1,
    S_READ_CMD  = 2'd2,
    S_READ_DATA = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     last_q, last_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [SW-1:0]     size_q, size_d;
  logic [SW-1:0]     beat_q, beat_d;
  logic [PORTS-1:0]  done_q, done_d;
  logic [PORTS-1:0]  rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              found_s;
  logic [IW-1:0]     pick_s;
  logic [AW-1:0]     pick_adr_s;
  logic [SW-1:0]     pick_size_s;
  logic              pick_we_s;
  logic [PORTS-1:0]  grant_oh_s;
  logic [31:0]       sel_wdata_s;
  logic [3:0]        sel_be_s;
  logic              last_beat_s;

  // Round-robin search: first requester strictly after last_q, then wrap to the lowest index.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IW{1'b0}};
    for (int j = 0; j < PORTS; j++) begin
      pick_s  = (!found_s && port_req_i[j] && (j > int'(last_q))) ? IW'(j) : pick_s;
      found_s = found_s | (port_req_i[j] && (j > int'(last_q)));
    end
    for (int j = 0; j < PORTS; j++) begin
      pick_s  = (!found_s && port_req_i[j] && (j <= int'(last_q))) ? IW'(j) : pick_s;
      found_s = found_s | (port_req_i[j] && (j <= int'(last_q)));
    end
  end

  // Field muxes: transfer parameters of the candidate port, beat data of the granted port.
  always_comb begin
    pick_adr_s  = {AW{1'b0}};
    pick_size_s = {SW{1'b0}};
    pick_we_s   = 1'b0;
    grant_oh_s  = {PORTS{1'b0}};
    sel_wdata_s = 32'h0000_0000;
    sel_be_s    = 4'h0;
    for (int j = 0; j < PORTS; j++) begin
      pick_adr_s    = pick_adr_s  | ({AW{pick_s == IW'(j)}} & port_adr_i[j*AW +: AW]);
      pick_size_s   = pick_size_s | ({SW{pick_s == IW'(j)}} & port_size_i[j*SW +: SW]);
      pick_we_s     = pick_we_s   | ((pick_s == IW'(j)) & port_we_i[j]);
      grant_oh_s[j] = (grant_q == IW'(j));
      sel_wdata_s   = sel_wdata_s | ({32{grant_q == IW'(j)}} & port_wdata_i[j*32 +: 32]);
      sel_be_s      = sel_be_s    | ({4{grant_q == IW'(j)}} & port_be_i[j*4 +: 4]);
    end
  end

  assign last_beat_s = (beat_q == (size_q - SW'(1'b1)));

  // Next-state logic and the handshake strobes that depend on the current state.
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_d             = last_q;
    addr_d             = addr_q;
    size_d             = size_q;
    beat_d             = beat_q;
    done_d             = {PORTS{1'b0}};
    rvalid_d           = {PORTS{1'b0}};
    rdata_d            = rdata_q;
    local_write_req_o  = 1'b0;
    local_read_req_o   = 1'b0;
    local_burstbegin_o = 1'b0;
    port_wdata_rd_o    = {PORTS{1'b0}};
    case (state_q)
      S_IDLE: begin
        // A port that is just seeing its done pulse still holds its request;
        // skip this cycle so the stale request is not granted again.
        if (found_s && (done_q == {PORTS{1'b0}})) begin
          grant_d = pick_s;
          last_d  = pick_s;
          addr_d  = pick_adr_s;
          size_d  = (pick_size_s == {SW{1'b0}}) ? SW'(1'b1) : pick_size_s;
          beat_d  = {SW{1'b0}};
          state_d = pick_we_s ? S_WRITE : S_READ_CMD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        local_write_req_o  = 1'b1;
        local_burstbegin_o = (beat_q == {SW{1'b0}});
        if (local_ready_i) begin
          port_wdata_rd_o = grant_oh_s;
          if (last_beat_s) begin
            done_d  = grant_oh_s;
            beat_d  = {SW{1'b0}};
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + SW'(1'b1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      S_READ_CMD: begin
        local_read_req_o   = 1'b1;
        local_burstbegin_o = 1'b1;
        if (local_ready_i) begin
          beat_d  = {SW{1'b0}};
          state_d = S_READ_DATA;
        end else begin
          state_d = S_READ_CMD;
        end
      end
      S_READ_DATA: begin
        if (local_rdata_valid_i) begin
          rvalid_d = grant_oh_s;
          rdata_d  = local_rdata_i;
          if (last_beat_s) begin
            done_d  = grant_oh_s;
            beat_d  = {SW{1'b0}};
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + SW'(1'b1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Command-side outputs: address/size only while a command is being presented, data only in WRITE.
  always_comb begin
    local_address_o = {AW{1'b0}};
    local_size_o    = {SW{1'b0}};
    local_wdata_o   = 32'h0000_0000;
    local_be_o      = 4'h0;
    if ((state_q == S_WRITE) || (state_q == S_READ_CMD)) begin
      local_address_o = addr_q;
      local_size_o    = size_q;
    end else begin
      local_address_o = {AW{1'b0}};
      local_size_o    = {SW{1'b0}};
    end
    if (state_q == S_WRITE) begin
      local_wdata_o = sel_wdata_s;
      local_be_o    = sel_be_s;
    end else begin
      local_wdata_o = 32'h0000_0000;
      local_be_o    = 4'h0;
    end
  end

  assign port_rdata_o       = rdata_q;
  assign port_rdata_valid_o = rvalid_q;
  assign port_done_o        = done_q;

  // State and datapath registers; reset parks the pointer on the last port so port 0 wins first.
  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state_q  <= S_IDLE;
      grant_q  <= {IW{1'b0}};
      last_q   <= IW'(PORTS - 1);
      addr_q   <= {AW{1'b0}};
      size_q   <= {SW{1'b0}};
      beat_q   <= {SW{1'b0}};
      done_q   <= {PORTS{1'b0}};
      rvalid_q <= {PORTS{1'b0}};
      rdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_local_arbiter.sv
// Directed bench for local_arbiter: a per-cycle vector table for single
// transfers plus hand-written sequences for reset and round-robin order.
module tb_local_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  port_req_i;
  logic [2:0]  port_we_i;
  logic [68:0] port_adr_i;
  logic [20:0] port_size_i;
  logic [95:0] port_wdata_i;
  logic [11:0] port_be_i;
  logic [2:0]  port_wdata_rd_o;
  logic [31:0] port_rdata_o;
  logic [2:0]  port_rdata_valid_o;
  logic [2:0]  port_done_o;
  logic [22:0] local_address_o;
  logic        local_write_req_o;
  logic        local_read_req_o;
  logic        local_burstbegin_o;
  logic [31:0] local_wdata_o;
  logic [3:0]  local_be_o;
  logic [6:0]  local_size_o;
  logic        local_ready_i;
  logic [31:0] local_rdata_i;
  logic        local_rdata_valid_i;

  local_arbiter #(.PORTS(3), .AW(23), .SW(7)) dut (
    .local_clk_i        (clk),
    .local_reset_n_i    (rst_n),
    .port_req_i         (port_req_i),
    .port_we_i          (port_we_i),
    .port_adr_i         (port_adr_i),
    .port_size_i        (port_size_i),
    .port_wdata_i       (port_wdata_i),
    .port_be_i          (port_be_i),
    .port_wdata_rd_o    (port_wdata_rd_o),
    .port_rdata_o       (port_rdata_o),
    .port_rdata_valid_o (port_rdata_valid_o),
    .port_done_o        (port_done_o),
    .local_address_o    (local_address_o),
    .local_write_req_o  (local_write_req_o),
    .local_read_req_o   (local_read_req_o),
    .local_burstbegin_o (local_burstbegin_o),
    .local_wdata_o      (local_wdata_o),
    .local_be_o         (local_be_o),
    .local_size_o       (local_size_o),
    .local_ready_i      (local_ready_i),
    .local_rdata_i      (local_rdata_i),
    .local_rdata_valid_i(local_rdata_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic        we;
    int          port;
    logic [22:0] adr;
    logic [6:0]  size;
    logic [31:0] wd;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ewr;
    logic        erd;
    logic        ebb;
    logic [2:0]  epop;
    logic [2:0]  erv;
    logic [2:0]  edone;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = -1;

  function automatic vec_t mk(input logic [2:0] req, input logic we, input int port,
                              input logic [22:0] adr, input logic [6:0] size, input logic [31:0] wd,
                              input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic ewr, input logic erd, input logic ebb,
                              input logic [2:0] epop, input logic [2:0] erv, input logic [2:0] edone);
    vec_t v;
    v.req = req; v.we = we; v.port = port; v.adr = adr; v.size = size; v.wd = wd;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.ewr = ewr; v.erd = erd; v.ebb = ebb;
    v.epop = epop; v.erv = erv; v.edone = edone;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h want %h", nm, vec_idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wr"},    {31'd0, local_write_req_o}, 32'd0);
    chk({tag, " rd"},    {31'd0, local_read_req_o}, 32'd0);
    chk({tag, " bb"},    {31'd0, local_burstbegin_o}, 32'd0);
    chk({tag, " adr"},   {9'd0, local_address_o}, 32'd0);
    chk({tag, " size"},  {25'd0, local_size_o}, 32'd0);
    chk({tag, " wdata"}, local_wdata_o, 32'd0);
    chk({tag, " be"},    {28'd0, local_be_o}, 32'd0);
    chk({tag, " pop"},   {29'd0, port_wdata_rd_o}, 32'd0);
    chk({tag, " rv"},    {29'd0, port_rdata_valid_o}, 32'd0);
    chk({tag, " done"},  {29'd0, port_done_o}, 32'd0);
    chk({tag, " rdata"}, port_rdata_o, 32'd0);
  endtask

  // Port of interest gets the row's values; the others get distinct values so a wrong mux shows up.
  task automatic drive(input vec_t v);
    port_req_i = v.req;
    port_we_i  = {3{v.we}};
    for (int p = 0; p < 3; p++) begin
      port_adr_i[p*23 +: 23]  = (p == v.port) ? v.adr : (v.adr ^ 23'h000055);
      port_size_i[p*7 +: 7]   = (p == v.port) ? v.size : (v.size + 7'd3);
      port_wdata_i[p*32 +: 32] = (p == v.port) ? v.wd : ~v.wd;
      port_be_i[p*4 +: 4]     = (p == v.port) ? v.wd[3:0] : ~v.wd[3:0];
    end
    local_ready_i       = v.rdy;
    local_rdata_valid_i = v.rv;
    local_rdata_i       = v.rd;
  endtask

  task automatic drive_all(input logic [2:0] req, input logic [2:0] we, input logic [6:0] sz);
    port_req_i = req;
    port_we_i  = we;
    for (int p = 0; p < 3; p++) begin
      port_adr_i[p*23 +: 23]   = 23'h000400 + 23'(p);
      port_size_i[p*7 +: 7]    = sz;
      port_wdata_i[p*32 +: 32] = 32'hC0DE_0000 + 32'(p);
      port_be_i[p*4 +: 4]      = 4'hF;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a write pop and returns it; zero means the budget ran out.
  task automatic wait_pop(output logic [2:0] pop);
    pop = 3'b000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (port_wdata_rd_o != 3'b000) begin
        pop = port_wdata_rd_o;
        break;
      end
    end
  endtask

  logic [31:0] prev_rd;
  logic [2:0]  pop;
  logic [2:0]  exp_seq [6];
  int          ng;

  initial begin
    // Write, port 1, adr 0x100, size 4, ready always high.
    tbl.push_back(mk(3'b010,1,1,23'h100,7'd4,32'hA000_0000,1,0,0, 0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b010,1,1,23'h100,7'd4,32'hA000_0000,1,0,0, 1,0,1,3'b010,3'b000,3'b000));
    tbl.push_back(mk(3'b010,1,1,23'h100,7'd4,32'hA000_0011,1,0,0, 1,0,0,3'b010,3'b000,3'b000));
    tbl.push_back(mk(3'b010,1,1,23'h100,7'd4,32'hA000_0022,1,0,0, 1,0,0,3'b010,3'b000,3'b000));
    tbl.push_back(mk(3'b010,1,1,23'h100,7'd4,32'hA000_0033,1,0,0, 1,0,0,3'b010,3'b000,3'b000));
    tbl.push_back(mk(3'b010,1,1,23'h100,7'd4,32'hA000_0044,1,0,0, 0,0,0,3'b000,3'b000,3'b010));
    tbl.push_back(mk(3'b000,1,1,23'h100,7'd4,32'hA000_0044,1,0,0, 0,0,0,3'b000,3'b000,3'b000));
    // Write, port 2, size 4, ready toggling: pops only on ready-high cycles, data held between.
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0005,1,0,0, 0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0005,1,0,0, 1,0,1,3'b100,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0016,0,0,0, 1,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0016,1,0,0, 1,0,0,3'b100,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0027,0,0,0, 1,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0027,1,0,0, 1,0,0,3'b100,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0038,0,0,0, 1,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0038,1,0,0, 1,0,0,3'b100,3'b000,3'b000));
    tbl.push_back(mk(3'b100,1,2,23'h2A0,7'd4,32'hB000_0049,1,0,0, 0,0,0,3'b000,3'b000,3'b100));
    tbl.push_back(mk(3'b000,1,2,23'h2A0,7'd4,32'hB000_0049,1,0,0, 0,0,0,3'b000,3'b000,3'b000));
    // Read, port 0, size 8, ready low 3 cycles; stray rdata_valid during the command is ignored.
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,0,0,            0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,0,0,            0,1,1,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'hDEAD_BEEF, 0,1,1,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,0,0,            0,1,1,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,1,0,0,            0,1,1,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0000, 0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0001, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b000,0,0,23'h3000,7'd8,32'h0,0,0,32'h5555_5555, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b000,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0002, 0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0003, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0004, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0005, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0006, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h1111_0007, 0,0,0,3'b000,3'b001,3'b000));
    tbl.push_back(mk(3'b001,0,0,23'h3000,7'd8,32'h0,0,1,32'h9999_9999, 0,0,0,3'b000,3'b001,3'b001));
    tbl.push_back(mk(3'b000,0,0,23'h3000,7'd8,32'h0,0,0,0,            0,0,0,3'b000,3'b000,3'b000));
    // Read, port 1, size 0 -> treated as one beat.
    tbl.push_back(mk(3'b010,0,1,23'h07F,7'd0,32'h0,1,0,0,             0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b010,0,1,23'h07F,7'd0,32'h0,1,0,0,             0,1,1,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b010,0,1,23'h07F,7'd0,32'h0,1,1,32'hE0E0_1234, 0,0,0,3'b000,3'b000,3'b000));
    tbl.push_back(mk(3'b010,0,1,23'h07F,7'd0,32'h0,1,0,0,             0,0,0,3'b000,3'b010,3'b010));
    tbl.push_back(mk(3'b000,0,1,23'h07F,7'd0,32'h0,1,0,0,             0,0,0,3'b000,3'b000,3'b000));

    // Reset state.
    rst_n = 1'b0;
    drive_all(3'b000, 3'b000, 7'd0);
    local_ready_i = 1'b0; local_rdata_i = 32'h0; local_rdata_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table: drive just after the edge, compare at the falling edge.
    prev_rd = 32'h0;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      vec_idx = i;
      step();
      drive(v);
      @(negedge clk);
      chk("wr",    {31'd0, local_write_req_o},  {31'd0, v.ewr});
      chk("rd",    {31'd0, local_read_req_o},   {31'd0, v.erd});
      chk("bb",    {31'd0, local_burstbegin_o}, {31'd0, v.ebb});
      chk("pop",   {29'd0, port_wdata_rd_o},    {29'd0, v.epop});
      chk("rv",    {29'd0, port_rdata_valid_o}, {29'd0, v.erv});
      chk("done",  {29'd0, port_done_o},        {29'd0, v.edone});
      chk("adr",   {9'd0, local_address_o},     (v.ewr | v.erd) ? {9'd0, v.adr} : 32'd0);
      chk("size",  {25'd0, local_size_o},
          (v.ewr | v.erd) ? ((v.size == 7'd0) ? 32'd1 : {25'd0, v.size}) : 32'd0);
      chk("wdata", local_wdata_o,               v.ewr ? v.wd : 32'd0);
      chk("be",    {28'd0, local_be_o},         v.ewr ? {28'd0, v.wd[3:0]} : 32'd0);
      if (v.erv != 3'b000) chk("rdata", port_rdata_o, prev_rd);
      prev_rd = v.rd;
    end

    // Reset asserted in the middle of a port 2 read burst.
    vec_idx = 100;
    step();
    drive_all(3'b100, 3'b000, 7'd8);
    local_ready_i = 1'b1; local_rdata_valid_i = 1'b0;
    step();                                   // READ_CMD
    step();                                   // READ_DATA
    local_rdata_valid_i = 1'b1; local_rdata_i = 32'hCAFE_0001;
    step();
    chk("midburst rv", {29'd0, port_rdata_valid_o}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    port_req_i = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("stray rv 1", {29'd0, port_rdata_valid_o}, 32'd0);
    step();
    chk("stray rv 2", {29'd0, port_rdata_valid_o}, 32'd0);
    chk("stray rdata", port_rdata_o, 32'd0);
    local_rdata_valid_i = 1'b0;
    drive_all(3'b111, 3'b111, 7'd1);
    wait_pop(pop);
    chk("first grant after reset", {29'd0, pop}, 32'd1);

    // Round robin with all ports requesting continuously from a fresh reset.
    vec_idx = 200;
    drive_all(3'b000, 3'b000, 7'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
    drive_all(3'b111, 3'b111, 7'd1);
    local_ready_i = 1'b1;
    ng = 0;
    for (int g = 0; g < 6; g++) begin
      wait_pop(pop);
      vec_idx = 200 + g;
      chk("rr grant", {29'd0, pop}, {29'd0, exp_seq[g]});
      if (pop == 3'b000) break;
      ng++;
    end
    chk("rr grant count", ng, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
